// File: rtl/fixed_point_mul_sequencer_pkg.sv
// Shared definitions for the fixed-point multiply sequencer: FSM encoding and
// partial-product shift amounts.
package fpu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPp0,
        StPp1,
        StPp2,
        StPp3,
        StDone
    } state_e;

    localparam int unsigned AccWidth = 64;

    localparam logic [5:0] PpShift0 = 6'd0;
    localparam logic [5:0] PpShift1 = 6'd16;
    localparam logic [5:0] PpShift2 = 6'd16;
    localparam logic [5:0] PpShift3 = 6'd32;

endpackage

// File: rtl/fixed_point_mul_sequencer_if.sv
// Request/result handshake between a client and the fixed-point multiply sequencer.
interface fixed_point_mul_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] operand_1;
    logic [WIDTH-1:0] operand_2;
    logic [WIDTH-1:0] result;
    logic             ready;
    logic             busy;

    modport master (
        output start, operand_1, operand_2,
        input  result, ready, busy
    );

    modport slave (
        input  start, operand_1, operand_2,
        output result, ready, busy
    );
endinterface

// File: rtl/fixed_point_mul_sequencer_mul_accumulator.sv
// 64-bit shift-add accumulator: clear wins over enable, addend is shifted before the add.
module mul_accumulator
    import fpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic [31:0]         i_addend,
    input  logic [5:0]          i_shift,
    output logic [AccWidth-1:0] o_acc
);
    logic [AccWidth-1:0] r_acc;
    logic [AccWidth-1:0] w_acc_next;

    always_comb begin
        w_acc_next = r_acc;
        if (i_clr) begin
            w_acc_next = '0;
        end else if (i_en) begin
            w_acc_next = r_acc + ({32'd0, i_addend} << i_shift);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

    assign o_acc = r_acc;
endmodule

// File: rtl/fixed_point_mul_sequencer.sv
// Unsigned fixed-point multiplier sequenced over an external 16x16 multiplier in four
// partial products. Define FIXED_POINT_MUL_SATURATE_EN to saturate on overflow.
module fixed_point_mul_sequencer
    import fpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FBITS = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    fixed_point_mul_sequencer_if.slave  bus,
    output logic [15:0]                 mult_operand_1,
    output logic [15:0]                 mult_operand_2,
    input  logic [31:0]                 mult_product
);
    state_e              r_state;
    state_e              w_state_next;
    logic [31:0]         r_op1;
    logic [31:0]         r_op2;
    logic [WIDTH-1:0]    r_result;
    logic                r_ready;
    logic                w_accept;
    logic                w_mul_en;
    logic [5:0]          w_shift;
    logic [AccWidth-1:0] w_acc;
    logic [WIDTH-1:0]    w_result_next;
    logic                w_unused_acc;

    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_mul_en       = 1'b0;
        w_shift        = PpShift0;
        mult_operand_1 = '0;
        mult_operand_2 = '0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = StPp0;
                end
            end
            StPp0: begin
                mult_operand_1 = r_op1[15:0];
                mult_operand_2 = r_op2[15:0];
                w_mul_en       = 1'b1;
                w_shift        = PpShift0;
                w_state_next   = StPp1;
            end
            StPp1: begin
                mult_operand_1 = r_op1[31:16];
                mult_operand_2 = r_op2[15:0];
                w_mul_en       = 1'b1;
                w_shift        = PpShift1;
                w_state_next   = StPp2;
            end
            StPp2: begin
                mult_operand_1 = r_op1[15:0];
                mult_operand_2 = r_op2[31:16];
                w_mul_en       = 1'b1;
                w_shift        = PpShift2;
                w_state_next   = StPp3;
            end
            StPp3: begin
                mult_operand_1 = r_op1[31:16];
                mult_operand_2 = r_op2[31:16];
                w_mul_en       = 1'b1;
                w_shift        = PpShift3;
                w_state_next   = StDone;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_result_next = w_acc[WIDTH+FBITS-1:FBITS];
`ifdef FIXED_POINT_MUL_SATURATE_EN
        if (|w_acc[AccWidth-1:WIDTH+FBITS]) begin
            w_result_next = '1;
        end
`endif
    end

    // Bits outside the result window only matter when saturation is enabled.
    assign w_unused_acc = ^{w_acc[AccWidth-1:WIDTH+FBITS], w_acc[FBITS-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_op1    <= '0;
            r_op2    <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (r_state == StDone);
            if (w_accept) begin
                r_op1 <= 32'(bus.operand_1);
                r_op2 <= 32'(bus.operand_2);
            end
            if (r_state == StDone) begin
                r_result <= w_result_next;
            end
        end
    end

    mul_accumulator u_acc (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_accept),
        .i_en     (w_mul_en),
        .i_addend (mult_product),
        .i_shift  (w_shift),
        .o_acc    (w_acc)
    );

    assign bus.result = r_result;
    assign bus.ready  = r_ready;
    // Busy covers the whole operation including the ready cycle.
    assign bus.busy   = (r_state != StIdle) || r_ready;
endmodule

// File: tb/tb_fixed_point_mul_sequencer.sv
// Directed bench for fixed_point_mul_sequencer with a behavioural 16x16 multiplier.
module tb_fixed_point_mul_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mult_operand_1;
    logic [15:0] mult_operand_2;
    logic [31:0] mult_product;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] b2b_a   [3] = '{32'h0000_0600, 32'h0001_0000, 32'h0001_2345};
    logic [31:0] b2b_b   [3] = '{32'h0000_0800, 32'h0001_0000, 32'h0001_0001};
    logic [31:0] b2b_exp [3] = '{32'h0000_0C00, 32'h0040_0000, 32'h0048_D188};

    fixed_point_mul_sequencer_if #(.WIDTH(32)) bus ();

    fixed_point_mul_sequencer #(
        .WIDTH (32),
        .FBITS (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .mult_operand_1 (mult_operand_1),
        .mult_operand_2 (mult_operand_2),
        .mult_product   (mult_product)
    );

    assign mult_product = {16'd0, mult_operand_1} * {16'd0, mult_operand_2};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; runs one multiply and watches a 12-cycle window.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int inject_lat);
        int lat;
        int seen;
        int first_lat;
        lat = 0;
        seen = 0;
        first_lat = 0;
        bus.start = 1'b1;
        bus.operand_1 = a;
        bus.operand_2 = b;
        repeat (12) begin
            @(negedge clk);
            lat++;
            bus.start = (lat == inject_lat);
            if (lat == inject_lat) begin
                bus.operand_1 = 32'h0000_0007;
                bus.operand_2 = 32'h0000_0009;
            end
            if (lat == 1) check({tag, "_busy_pp0"}, 64'(bus.busy), 64'd1);
            if (lat == 2) begin
                check({tag, "_pp1_op1"}, 64'(mult_operand_1), 64'(a[31:16]));
                check({tag, "_pp1_op2"}, 64'(mult_operand_2), 64'(b[15:0]));
            end
            if (bus.ready === 1'b1) begin
                seen++;
                if (seen == 1) begin
                    first_lat = lat;
                    check({tag, "_result"}, 64'(bus.result), 64'(exp));
                    check({tag, "_busy_ready"}, 64'(bus.busy), 64'd1);
                end
            end
        end
        check({tag, "_latency"}, 64'(first_lat), 64'd6);
        check({tag, "_pulses"}, 64'(seen), 64'd1);
        check({tag, "_hold"}, 64'(bus.result), 64'(exp));
        check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
        check({tag, "_idle_ops"}, 64'({mult_operand_1, mult_operand_2}), 64'd0);
    endtask

    initial begin
        int seen;
        int lat;
        int last;
        int idx;
        logic [31:0] sat_exp;

        bus.start = 1'b0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        #1;
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_ready", 64'(bus.ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ops", 64'({mult_operand_1, mult_operand_2}), 64'd0);

        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        // Start issued in the very first cycle after reset release.
        run_op("mul_1p5x2", 32'h0000_0600, 32'h0000_0800, 32'h0000_0C00, 0);
        run_op("mul_hihi", 32'h0001_0000, 32'h0001_0000, 32'h0040_0000, 0);
`ifdef FIXED_POINT_MUL_SATURATE_EN
        sat_exp = 32'hFFFF_FFFF;
`else
        sat_exp = 32'hFF80_0000;
`endif
        run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, sat_exp, 0);
        run_op("mul_mixed", 32'h0001_2345, 32'h0001_0001, 32'h0048_D188, 0);
        run_op("mul_small", 32'h0001_8000, 32'h0000_0002, 32'h0000_00C0, 0);
        run_op("mul_ignore", 32'h0000_0400, 32'h0000_0C00, 32'h0000_0C00, 2);

        // Reset during PP2 aborts the operation.
        bus.start = 1'b1;
        bus.operand_1 = 32'h0001_0000;
        bus.operand_2 = 32'h0001_0000;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_ready", 64'(bus.ready), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_ops", 64'({mult_operand_1, mult_operand_2}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.ready === 1'b1) seen++;
        end
        check("abort_no_ready", 64'(seen), 64'd0);
        check("abort_result_kept", 64'(bus.result), 64'd0);
        run_op("mul_after_abort", 32'h0000_0400, 32'h0000_0C00, 32'h0000_0C00, 0);

        // Start held high: a new operation starts in each IDLE cycle.
        idx = 0;
        lat = 0;
        last = 0;
        bus.start = 1'b1;
        bus.operand_1 = b2b_a[0];
        bus.operand_2 = b2b_b[0];
        repeat (24) begin
            @(negedge clk);
            lat++;
            if (bus.ready === 1'b1 && idx < 3) begin
                check($sformatf("b2b_result_%0d", idx), 64'(bus.result), 64'(b2b_exp[idx]));
                check($sformatf("b2b_gap_%0d", idx), 64'(lat - last), 64'd6);
                last = lat;
                idx++;
                if (idx < 3) begin
                    bus.operand_1 = b2b_a[idx];
                    bus.operand_2 = b2b_b[idx];
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        check("b2b_count", 64'(idx), 64'd3);
        check("b2b_busy_end", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
